muldiv_unit: RTL

- Iterative multiply/divide unit that sits directly downstream of the datapath register file, beside the ALU.
- Consumes the two register operands (srca/srcb) and computes MULT, MULTU, DIV and DIVU into dedicated HI/LO registers.
- Uses a start/busy/done handshake so the controller can stall the single-cycle datapath.
- HI/LO are read by MFHI/MFLO muxing into the result path and written directly by MTHI/MTLO.

---
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_unit : iterative MULT/MULTU/DIV/DIVU unit feeding dedicated HI/LO    |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_fix  = 2'd2;
  localparam logic [1:0] c_done = 2'd3;

  localparam logic [CNTW-1:0] c_last = CNTW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               div_zero;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_idle;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    // op[0]==0 selects the signed variants
    sign_a   = ~op[0] & a[WIDTH-1];
    sign_b   = ~op[0] & b[WIDTH-1];
    mag_a    = sign_a ? -a : a;
    mag_b    = sign_b ? -b : b;
    div_zero = op[1] && (b == '0);

    // Trial subtraction needs one extra bit; its MSB is the restore decision.
    rem_shift = {rem_q, opa_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};

    prod    = neg_q  ? -acc_q : acc_q;
    quo_fix = neg_q  ? -opa_q : opa_q;
    rem_fix = rneg_q ? -rem_q : rem_q;

    case (state_q)
      c_idle, c_done: begin
        state_d = c_idle;
        if (start) begin
          state_d = c_run;
          cnt_d   = '0;
          div_d   = op[1];
          neg_d   = sign_a ^ sign_b;
          rneg_d  = sign_a;
          dz_d    = div_zero;
          // Raw dividend is kept for div-by-zero so HI can return it unchanged.
          opa_d   = div_zero ? a : mag_a;
          opb_d   = mag_b;
          acc_d   = '0;
          rem_d   = '0;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      c_run: begin
        if (dz_q) begin
          hi_d    = opa_q;
          lo_d    = '1;
          state_d = c_done;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (div_q) begin
            if (!rem_diff[WIDTH]) begin
              rem_d = rem_diff[WIDTH-1:0];
              opa_d = {opa_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = rem_shift[WIDTH-1:0];
              opa_d = {opa_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0} +
                    (opb_q[WIDTH-1] ? {{WIDTH{1'b0}}, opa_q} : {(2*WIDTH){1'b0}});
            opb_d = {opb_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == c_last) state_d = c_fix;
        end
      end
      c_fix: begin
        if (div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = c_done;
      end
      default: state_d = c_idle;
    endcase
  end

  always_comb begin
    busy = (state_q == c_run) || (state_q == c_fix);
    done = (state_q == c_done);
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
`default_nettype wire
